// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage (PC, imem req/ack, skid-buffered IF/ID, redirect flush with stale-response discard)
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [6:0]  ifid_opcode
);
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, stale_addr, skid_pc, skid_instr, target;
  logic xfer;
  assign target = redirect_pc & ~32'h3;
  always_ff @(posedge clk)
    state <= rst ? FETCH : state_nxt;
  always_comb
    state_nxt = (state == FETCH) ? (redirect_valid ? (xfer ? FETCH : DISCARD) : ((xfer && stall_in) ? HOLD : FETCH)) :
                (state == HOLD)  ? ((redirect_valid || !stall_in) ? FETCH : HOLD) :
                (state == DISCARD) ? (xfer ? FETCH : DISCARD) : FETCH;
  always_comb begin
    imem_req    = (state == FETCH || state == DISCARD) && !rst;
    imem_addr   = (state == DISCARD) ? stale_addr : pc;
    xfer        = imem_req && imem_ack;
    ifid_opcode = ifid_instr[6:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      stale_addr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      if (state == FETCH && !xfer) stale_addr <= pc;
      pc         <= target;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (state == FETCH) begin
      if (xfer) begin
        pc <= pc + 32'd4;
        if (stall_in) begin
          skid_pc    <= pc;
          skid_instr <= imem_rdata;
        end else begin
          ifid_valid <= 1'b1;
          ifid_pc    <= pc;
          ifid_instr <= imem_rdata;
        end
      end else if (!stall_in) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end
    end else if (state == HOLD) begin
      if (!stall_in) begin
        ifid_valid <= 1'b1;
        ifid_pc    <= skid_pc;
        ifid_instr <= skid_instr;
      end
    end else begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a behavioural model
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_instr;
  logic [6:0]  ifid_opcode;
  int checks = 0;
  int failures = 0;
  logic [31:0] seen_addr;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t        m_skid[$];
  bit          m_disc;
  logic [31:0] m_pc, m_stale, m_ipc, m_ins;
  bit          m_v;
  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall_in(stall_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_instr(ifid_instr), .ifid_opcode(ifid_opcode)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction
  assign imem_rdata = word_of(imem_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_step();
    bit hold = m_skid.size() != 0;
    bit req = !rst && !hold;
    logic [31:0] addr = m_disc ? m_stale : m_pc;
    bit x = req && imem_ack;
    ent_t e;
    if (rst) begin
      m_pc = 32'h0; m_stale = 32'h0; m_disc = 0; m_skid.delete();
      m_v = 0; m_ipc = 32'h0; m_ins = 32'h13;
    end else if (redirect_valid) begin
      if (m_disc) m_disc = !x;
      else if (!hold && !x) begin m_disc = 1; m_stale = m_pc; end
      m_pc = {redirect_pc[31:2], 2'b00};
      m_skid.delete();
      m_v = 0; m_ins = 32'h13;
    end else if (m_disc) begin
      m_v = 0; m_ins = 32'h13;
      if (x) m_disc = 0;
    end else if (hold) begin
      if (!stall_in) begin
        e = m_skid.pop_front();
        m_v = 1; m_ipc = e.pc; m_ins = e.instr;
      end
    end else if (x) begin
      if (stall_in) begin e.pc = m_pc; e.instr = word_of(addr); m_skid.push_back(e); end
      else begin m_v = 1; m_ipc = m_pc; m_ins = word_of(addr); end
      m_pc = m_pc + 32'd4;
    end else if (!stall_in) begin
      m_v = 0; m_ins = 32'h13;
    end
  endtask
  task automatic tick(input bit r, input bit ack, input bit stall, input bit redir, input logic [31:0] tgt);
    bit exp_req;
    @(negedge clk);
    rst = r; imem_ack = ack; stall_in = stall; redirect_valid = redir; redirect_pc = tgt;
    #1;
    exp_req = !r && m_skid.size() == 0;
    seen_addr = imem_addr;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_disc ? m_stale : m_pc);
    model_step();
    @(posedge clk);
    #1;
    chk("ifid_valid", 32'(ifid_valid), 32'(m_v));
    chk("ifid_instr", ifid_instr, m_ins);
    chk("ifid_opcode", 32'(ifid_opcode), 32'(m_ins[6:0]));
    if (m_v) chk("ifid_pc", ifid_pc, m_ipc);
  endtask
  task automatic do_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
  endtask
  initial begin
    do_reset();
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    chk("rst_pc", ifid_pc, 32'h0);
    chk("rst_instr", ifid_instr, 32'h13);
    chk("rst_opcode", 32'(ifid_opcode), 32'h13);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0, 0, 0);
      chk("seq_addr", seen_addr, 32'(i * 4));
      chk("seq_pc", ifid_pc, 32'(i * 4));
    end
    do_reset();
    for (int i = 0; i < 8; i++) tick(0, i[0], 0, 0, 0);
    do_reset();
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    chk("stall_hold_pc", ifid_pc, 32'h4);
    tick(0, 0, 1, 0, 0);
    tick(0, 1, 1, 0, 0);
    chk("stall_hold_pc3", ifid_pc, 32'h4);
    chk("hold_req_low", 32'(imem_req), 32'h0);
    tick(0, 1, 0, 0, 0);
    chk("release_pc", ifid_pc, 32'h8);
    tick(0, 1, 0, 0, 0);
    chk("after_release_addr", seen_addr, 32'hC);
    tick(0, 0, 0, 1, 32'h100);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("discard_valid", 32'(ifid_valid), 32'h0);
    tick(0, 1, 0, 0, 0);
    chk("redir_addr", seen_addr, 32'h100);
    chk("redir_pc", ifid_pc, 32'h100);
    tick(0, 1, 1, 0, 0);
    tick(0, 0, 1, 1, 32'h200);
    chk("hold_flush_valid", 32'(ifid_valid), 32'h0);
    chk("hold_flush_instr", ifid_instr, 32'h13);
    tick(0, 1, 0, 0, 0);
    chk("hold_redir_addr", seen_addr, 32'h200);
    tick(0, 1, 0, 1, 32'hFFFF_FFFF);
    tick(0, 1, 0, 0, 0);
    chk("wrap_top_addr", seen_addr, 32'hFFFF_FFFC);
    tick(0, 1, 0, 0, 0);
    chk("wrap_addr", seen_addr, 32'h0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    chk("late_ack_valid", 32'(ifid_valid), 32'h0);
    chk("late_ack_instr", ifid_instr, 32'h13);
    chk("late_ack_pc", ifid_pc, 32'h0);
    tick(0, 0, 0, 0, 0);
    chk("post_rst_addr", seen_addr, 32'h0);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
